// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request outstanding, and feeds decode through a slot plus a one-entry skid.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined; otherwise fetch_cnt/bubble_cnt are tied to 0.
module stage_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_2000),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallD,
  input  logic            flushF,
  input  logic [XLEN-1:0] flush_pc,
  input  logic [1:0]      pc_selD,
  input  logic [XLEN-1:0] branch_result,
  input  logic [XLEN-1:0] jump_result,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     bubble_cnt
);

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t          state_q,      state_n;
  logic [XLEN-1:0] pc_f_q,       pc_f_n;
  logic [XLEN-1:0] req_pc_q,     req_pc_n;
  logic            drop_q,       drop_n;
  logic            skid_valid_q, skid_valid_n;
  logic [XLEN-1:0] skid_instr_q, skid_instr_n;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_n;
  logic            valid_n;
  logic [XLEN-1:0] instr_n;
  logic [XLEN-1:0] pc_d_n;
  logic            req_valid_n;

  logic            redirect;
  logic            kill;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            accept;
  logic            resp;
  logic            resp_use;
  logic            slot_take;

  // Redirect/flush decode and handshake qualifiers
  always_comb begin
    redirect   = validD && !stallD && (pc_selD != 2'b00);
    kill       = flushF || redirect;
    if (flushF)
      raw_target = flush_pc;
    else if (pc_selD == 2'b10)
      raw_target = branch_result;
    else
      raw_target = jump_result;
    target     = raw_target & ~XLEN'(3);
    accept     = (state_q == ST_ISSUE) && imem_req_valid && imem_req_ready;
    resp       = (state_q == ST_WAIT) && imem_resp_valid;
    resp_use   = resp && !drop_q && !kill;
    slot_take  = !validD || !stallD;
  end

  // Next-state: fetch FSM, decode slot, skid buffer and request port
  always_comb begin
    state_n      = state_q;
    pc_f_n       = pc_f_q;
    req_pc_n     = req_pc_q;
    drop_n       = drop_q;
    skid_valid_n = skid_valid_q;
    skid_instr_n = skid_instr_q;
    skid_pc_n    = skid_pc_q;
    valid_n      = validD;
    instr_n      = instrD;
    pc_d_n       = pcD;

    unique case (state_q)
      ST_ISSUE: begin
        if (accept) begin
          pc_f_n   = pc_f_q + XLEN'(4);
          req_pc_n = pc_f_q;
          state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_n = ST_ISSUE;
          drop_n  = 1'b0;
        end
      end
      default: state_n = ST_ISSUE;
    endcase

    // Skid drains first so decode always sees program order
    if (slot_take) begin
      if (skid_valid_q) begin
        valid_n      = 1'b1;
        instr_n      = skid_instr_q;
        pc_d_n       = skid_pc_q;
        skid_valid_n = resp_use;
        if (resp_use) begin
          skid_instr_n = imem_resp_data;
          skid_pc_n    = req_pc_q;
        end
      end else if (resp_use) begin
        valid_n = 1'b1;
        instr_n = imem_resp_data;
        pc_d_n  = req_pc_q;
      end else begin
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
      end
    end else if (resp_use) begin
      skid_valid_n = 1'b1;
      skid_instr_n = imem_resp_data;
      skid_pc_n    = req_pc_q;
    end

    // A request accepted this cycle is still owed a response: wait for it and discard it
    if (kill) begin
      pc_f_n       = target;
      valid_n      = 1'b0;
      instr_n      = NOP_INSTR;
      skid_valid_n = 1'b0;
      if (accept || ((state_q == ST_WAIT) && !imem_resp_valid)) begin
        state_n = ST_WAIT;
        drop_n  = 1'b1;
      end else begin
        state_n = ST_ISSUE;
        drop_n  = 1'b0;
      end
    end

    req_valid_n = (state_n == ST_ISSUE) && !skid_valid_n;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ISSUE;
      pc_f_q         <= RESET_PC;
      req_pc_q       <= '0;
      drop_q         <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= NOP_INSTR;
      skid_pc_q      <= '0;
      validD         <= 1'b0;
      instrD         <= NOP_INSTR;
      pcD            <= '0;
      pc_plus4D      <= XLEN'(4);
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
    end else begin
      state_q        <= state_n;
      pc_f_q         <= pc_f_n;
      req_pc_q       <= req_pc_n;
      drop_q         <= drop_n;
      skid_valid_q   <= skid_valid_n;
      skid_instr_q   <= skid_instr_n;
      skid_pc_q      <= skid_pc_n;
      validD         <= valid_n;
      instrD         <= instr_n;
      pcD            <= pc_d_n;
      pc_plus4D      <= pc_d_n + XLEN'(4);
      imem_req_valid <= req_valid_n;
      imem_addr      <= pc_f_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Loaded-word and empty-slot counters, free-running and wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (resp_use)
        fetch_cnt_q <= fetch_cnt_q + 32'(1);
      if (!validD)
        bubble_cnt_q <= bubble_cnt_q + 32'(1);
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with a 1-cycle-latency instruction memory model.
module tb_stage_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_FETCH  = 32'd4;
  localparam logic [31:0] EXP_BUBBLE = 32'd8;
`else
  localparam logic [31:0] EXP_FETCH  = 32'd0;
  localparam logic [31:0] EXP_BUBBLE = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        flushF;
  logic [31:0] flush_pc;
  logic [1:0]  pc_selD;
  logic [31:0] branch_result;
  logic [31:0] jump_result;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  logic        pend;
  logic [31:0] paddr;

  stage_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stallD          (stallD),
    .flushF          (flushF),
    .flush_pc        (flush_pc),
    .pc_selD         (pc_selD),
    .branch_result   (branch_result),
    .jump_result     (jump_result),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instrD          (instrD),
    .pcD             (pcD),
    .pc_plus4D       (pc_plus4D),
    .validD          (validD),
    .fetch_cnt       (fetch_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: response one cycle after acceptance, reset alongside the core
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      paddr <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
    end else begin
      pend  <= 1'b0;
    end
  end
  assign imem_resp_valid = pend;
  assign imem_resp_data  = word(paddr);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; flushF = 1'b0; flush_pc = '0;
    pc_selD = 2'b00; branch_result = '0; jump_result = '0; imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_validD", 32'(validD), 32'd0);
    chk("rst_instrD", instrD, NOP);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pc_plus4D", pc_plus4D, 32'h4);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);

    // Sequential fetch from RESET_PC
    rst = 1'b0;
    tick();
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0", imem_addr, 32'h2000);
    chk("t1_instr_nop", instrD, NOP);
    tick();
    chk("t1_wait_req", 32'(imem_req_valid), 32'd0);
    chk("t1_wait_valid", 32'(validD), 32'd0);
    tick();
    chk("t1_valid0", 32'(validD), 32'd1);
    chk("t1_pcD0", pcD, 32'h2000);
    chk("t1_pc4D0", pc_plus4D, 32'h2004);
    chk("t1_instrD0", instrD, word(32'h2000));
    chk("t1_addr1", imem_addr, 32'h2004);
    tick();
    chk("t1_gap_valid", 32'(validD), 32'd0);
    tick();
    chk("t1_pcD1", pcD, 32'h2004);
    chk("t1_addr2", imem_addr, 32'h2008);
    tick();
    tick();
    chk("t2_pcD_br", pcD, 32'h2008);
    chk("t2_valid_br", 32'(validD), 32'd1);

    // Taken branch while the 0x200C request is being accepted
    pc_selD = 2'b10; branch_result = 32'h2100;
    tick();
    pc_selD = 2'b00;
    chk("t2_kill_valid", 32'(validD), 32'd0);
    chk("t2_kill_instr", instrD, NOP);
    chk("t2_kill_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t2_drop_valid", 32'(validD), 32'd0);
    chk("t2_new_req", 32'(imem_req_valid), 32'd1);
    chk("t2_new_addr", imem_addr, 32'h2100);
    tick();
    tick();
    chk("t2_valid_tgt", 32'(validD), 32'd1);
    chk("t2_pcD_tgt", pcD, 32'h2100);
    chk("t2_pc4D_tgt", pc_plus4D, 32'h2104);
    chk("t6_fetch_cnt", fetch_cnt, EXP_FETCH);
    chk("t6_bubble_cnt", bubble_cnt, EXP_BUBBLE);

    // Decode stall for three cycles; next word lands in the skid
    stallD = 1'b1;
    tick();
    chk("t3_hold_pc_a", pcD, 32'h2100);
    chk("t3_hold_v_a", 32'(validD), 32'd1);
    tick();
    chk("t3_hold_pc_b", pcD, 32'h2100);
    chk("t3_no_req_b", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t3_hold_pc_c", pcD, 32'h2100);
    chk("t3_hold_instr_c", instrD, word(32'h2100));
    chk("t3_no_req_c", 32'(imem_req_valid), 32'd0);
    stallD = 1'b0;
    tick();
    chk("t3_skid_pcD", pcD, 32'h2104);
    chk("t3_skid_instr", instrD, word(32'h2104));
    chk("t3_skid_valid", 32'(validD), 32'd1);
    chk("t3_resume_addr", imem_addr, 32'h2108);
    chk("t3_resume_req", 32'(imem_req_valid), 32'd1);
    tick();
    tick();
    chk("t3_next_pcD", pcD, 32'h2108);

    // Memory back-pressure for five cycles
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_req_held", 32'(imem_req_valid), 32'd1);
      chk("t4_addr_held", imem_addr, 32'h210C);
      chk("t4_no_valid", 32'(validD), 32'd0);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("t4_acc_valid", 32'(validD), 32'd0);
    tick();
    chk("t4_resp_valid", 32'(validD), 32'd1);
    chk("t4_resp_pcD", pcD, 32'h210C);

    // Flush beats a simultaneous jump; target alignment
    flushF = 1'b1; flush_pc = 32'h3003; pc_selD = 2'b01; jump_result = 32'h4000;
    tick();
    flushF = 1'b0; pc_selD = 2'b00;
    chk("t5_flush_valid", 32'(validD), 32'd0);
    tick();
    chk("t5_flush_addr", imem_addr, 32'h3000);
    chk("t5_flush_req", 32'(imem_req_valid), 32'd1);
    tick();
    tick();
    chk("t5_flush_pcD", pcD, 32'h3000);
    chk("t5_flush_pc4D", pc_plus4D, 32'h3004);

    // PC wrap at the top of the address space
    flushF = 1'b1; flush_pc = 32'hFFFF_FFFF;
    tick();
    flushF = 1'b0;
    tick();
    chk("t7_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("t7_top_pcD", pcD, 32'hFFFF_FFFC);
    chk("t7_wrap_pc4D", pc_plus4D, 32'h0);
    chk("t7_wrap_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
